// File: rtl/einstein_irq_pkg.sv
// Shared types and constants for the Einstein mode-2 interrupt controller.
// Holds the source indices, default vectors and the ED/4D RETI opcode bytes.
package einstein_irq_pkg;

    typedef enum logic [1:0] {
        SRC_KB   = 2'd0,
        SRC_ADC  = 2'd1,
        SRC_FIRE = 2'd2
    } src_e;

    localparam int NUM_SRC = 3;

    localparam logic [7:0] DEF_VEC_KB   = 8'h0E;
    localparam logic [7:0] DEF_VEC_ADC  = 8'h0A;
    localparam logic [7:0] DEF_VEC_FIRE = 8'h0C;
    localparam logic [7:0] DEF_VEC_NONE = 8'hFF;

    localparam logic [7:0] OP_ED = 8'hED;
    localparam logic [7:0] OP_4D = 8'h4D;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_GOT_ED = 1'b1
    } reti_state_e;

endpackage

// File: rtl/einstein_reti_decode.sv
// Watches M1 opcode fetches for the ED 4D (RETI) sequence and emits a
// one-cycle pulse when the 4D byte completes. Used only with EINSTEIN_IRQ_RETI_DECODE_EN.
module einstein_reti_decode
    import einstein_irq_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       m1_n_i,
    input  logic       mreq_n_i,
    input  logic       rd_n_i,
    input  logic [7:0] cpu_di_i,
    output logic       reti_o
);

    reti_state_e state_q, state_d;
    logic        rd_n_q;
    logic        fetch_q;
    logic [7:0]  di_q;
    logic        byte_ev;

    // Bus values are taken from the cycle before rd_n rises, while the read is still valid.
    assign byte_ev = rd_n_i & ~rd_n_q & fetch_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= RD_IDLE;
            rd_n_q  <= 1'b1;
            fetch_q <= 1'b0;
            di_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            rd_n_q  <= rd_n_i;
            fetch_q <= ~m1_n_i & ~mreq_n_i;
            di_q    <= cpu_di_i;
        end
    end

    always_comb begin
        state_d = state_q;
        if (byte_ev) begin
            case (state_q)
                RD_IDLE:   state_d = (di_q == OP_ED) ? RD_GOT_ED : RD_IDLE;
                RD_GOT_ED: state_d = (di_q == OP_ED) ? RD_GOT_ED : RD_IDLE;
                default:   state_d = RD_IDLE;
            endcase
        end
    end

    always_comb begin
        reti_o = byte_ev & (state_q == RD_GOT_ED) & (di_q == OP_4D);
    end

endmodule

// File: rtl/einstein_irq_ctrl.sv
// Mode-2 interrupt controller: latches KB/ADC/FIRE requests, daisy-chains them with the CTC,
// drives the INTA vector and tracks in-service until RETI. EINSTEIN_IRQ_RETI_DECODE_EN selects the internal RETI decoder.
module einstein_irq_ctrl
    import einstein_irq_pkg::*;
#(
    parameter logic [7:0] VEC_KB   = DEF_VEC_KB,
    parameter logic [7:0] VEC_ADC  = DEF_VEC_ADC,
    parameter logic [7:0] VEC_FIRE = DEF_VEC_FIRE,
    parameter logic [7:0] VEC_NONE = DEF_VEC_NONE
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       m1_n,
    input  logic       iorq_n,
    input  logic       mreq_n,
    input  logic       rd_n,
    input  logic [7:0] cpu_di,
    input  logic [2:0] src_evt,
    input  logic [2:0] msk_wr,
    input  logic       msk_din,
    input  logic [2:0] clr_rd,
    input  logic       reti_i,
    input  logic       ctc_int_n,
    input  logic       ctc_ieo,
    output logic       ctc_iei,
    output logic       int_n,
    output logic       vec_oe,
    output logic [7:0] vec,
    output logic [2:0] in_service
);

    logic [2:0] evt_q, evt_prev_q, mwr_q, mwr_prev_q, clr_q, clr_prev_q;
    logic       msk_din_q;
    logic       inta_q, inta_prev_q;
    logic [2:0] mask_q, mask_d, pend_q, pend_d, ins_q, ins_d;
    logic       int_n_q, int_n_d;
    logic       vec_oe_q, vec_oe_d;
    logic [7:0] vec_q, vec_d;

    logic [2:0] evt_rise, mwr_rise, clr_rise, req, grant;
    logic       inta, inta_start, adc_en, fire_en, ctc_win, reti_evt;

    assign inta       = ~m1_n & ~iorq_n;
    assign inta_start = inta_q & ~inta_prev_q;
    assign evt_rise   = evt_q & ~evt_prev_q;
    assign mwr_rise   = mwr_q & ~mwr_prev_q;
    assign clr_rise   = clr_q & ~clr_prev_q;

    // Daisy chain: KB sits above the CTC, ADC and FIRE hang off the CTC's IEO.
    assign adc_en  = ~ins_q[SRC_KB] & ctc_ieo;
    assign fire_en = adc_en & ~ins_q[SRC_ADC];
    assign req     = pend_q & ~ins_q & {fire_en, adc_en, 1'b1};

`ifdef EINSTEIN_IRQ_RETI_DECODE_EN
    logic unused_reti;
    assign unused_reti = reti_i;

    einstein_reti_decode u_reti_decode (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .m1_n_i   (m1_n),
        .mreq_n_i (mreq_n),
        .rd_n_i   (rd_n),
        .cpu_di_i (cpu_di),
        .reti_o   (reti_evt)
    );
`else
    logic reti_q;
    logic unused_bus;
    assign unused_bus = ^{mreq_n, rd_n, cpu_di};

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) reti_q <= 1'b0;
        else       reti_q <= reti_i;
    end
    assign reti_evt = reti_i & ~reti_q;
`endif

    always_comb begin
        grant   = 3'b000;
        ctc_win = 1'b0;
        if (req[SRC_KB])        grant[SRC_KB]   = 1'b1;
        else if (!ctc_ieo)      ctc_win         = 1'b1;
        else if (req[SRC_ADC])  grant[SRC_ADC]  = 1'b1;
        else if (req[SRC_FIRE]) grant[SRC_FIRE] = 1'b1;
    end

    always_comb begin
        mask_d = mask_q;
        pend_d = pend_q;
        ins_d  = ins_q;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (mwr_rise[s]) begin
                mask_d[s] = msk_din_q;
                if (msk_din_q) pend_d[s] = 1'b0;
            end
            if (clr_rise[s]) pend_d[s] = 1'b0;
        end
        if (reti_evt) begin
            if (ins_q[SRC_KB])          ins_d[SRC_KB]   = 1'b0;
            else if (ctc_ieo) begin
                if (ins_q[SRC_ADC])     ins_d[SRC_ADC]  = 1'b0;
                else if (ins_q[SRC_FIRE]) ins_d[SRC_FIRE] = 1'b0;
            end
        end
        if (inta_start) begin
            pend_d = pend_d & ~grant;
            ins_d  = ins_d | grant;
        end
        // New requests are applied last so a same-cycle set beats any clear.
        pend_d = pend_d | (evt_rise & ~mask_q);
    end

    always_comb begin
        int_n_d = ~((|req) | ~ctc_int_n);
    end

    always_comb begin
        vec_oe_d = vec_oe_q;
        vec_d    = vec_q;
        if (!inta) begin
            vec_oe_d = 1'b0;
            vec_d    = 8'h00;
        end else if (inta_start) begin
            vec_oe_d = 1'b1;
            if (grant[SRC_KB])        vec_d = VEC_KB;
            else if (ctc_win) begin
                vec_oe_d = 1'b0;
                vec_d    = 8'h00;
            end
            else if (grant[SRC_ADC])  vec_d = VEC_ADC;
            else if (grant[SRC_FIRE]) vec_d = VEC_FIRE;
            else                      vec_d = VEC_NONE;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            evt_q       <= 3'b000;
            evt_prev_q  <= 3'b000;
            mwr_q       <= 3'b000;
            mwr_prev_q  <= 3'b000;
            clr_q       <= 3'b000;
            clr_prev_q  <= 3'b000;
            msk_din_q   <= 1'b0;
            inta_q      <= 1'b0;
            inta_prev_q <= 1'b0;
            mask_q      <= 3'b111;
            pend_q      <= 3'b000;
            ins_q       <= 3'b000;
            int_n_q     <= 1'b1;
            vec_oe_q    <= 1'b0;
            vec_q       <= 8'h00;
        end else begin
            evt_q       <= src_evt;
            evt_prev_q  <= evt_q;
            mwr_q       <= msk_wr;
            mwr_prev_q  <= mwr_q;
            clr_q       <= clr_rd;
            clr_prev_q  <= clr_q;
            msk_din_q   <= msk_din;
            inta_q      <= inta;
            inta_prev_q <= inta_q;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            ins_q       <= ins_d;
            int_n_q     <= int_n_d;
            vec_oe_q    <= vec_oe_d;
            vec_q       <= vec_d;
        end
    end

    assign ctc_iei    = ~ins_q[SRC_KB];
    assign int_n      = int_n_q;
    assign vec_oe     = vec_oe_q;
    assign vec        = vec_q;
    assign in_service = ins_q;

endmodule
